// File: rtl/mnist_pkg.sv
// Shared constants and types for the MNIST inference datapath and its consumers.
package mnist_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned N_CLASSES  = 10;
  localparam int unsigned IDX_WIDTH  = 4;

  typedef logic signed [DATA_WIDTH-1:0] score_t;
  typedef logic [IDX_WIDTH-1:0]         idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } argmax_state_t;

  // Most negative representable score, seeds the runner-up slot.
  localparam score_t SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/top2_update.sv
// Combinational top-2 tracker step: folds one score into the running best/second.
module top2_update
  import mnist_pkg::*;
(
  input  logic   first,
  input  score_t s,
  input  idx_t   cnt,
  input  score_t best,
  input  score_t second,
  input  idx_t   bidx,
  output score_t best_next,
  output score_t second_next,
  output idx_t   bidx_next
);

  // Strict compares keep the lowest index on ties; an equal score drops into second.
  always_comb begin
    best_next   = best;
    second_next = second;
    bidx_next   = bidx;
    if (first) begin
      best_next   = s;
      second_next = SCORE_MIN;
      bidx_next   = '0;
    end else if (s > best) begin
      second_next = best;
      best_next   = s;
      bidx_next   = cnt;
    end else if (s > second) begin
      second_next = s;
    end
  end

endmodule

// File: rtl/argmax_classifier_fix16.sv
// Scans the class scores after inference completes and reports argmax, best score and margin.
module argmax_classifier_fix16
  import mnist_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dnn_done,
  output logic [IDX_WIDTH-1:0]  out_idx,
  input  logic [DATA_WIDTH-1:0] score,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ack,
  output logic [IDX_WIDTH-1:0]  digit,
  output logic [DATA_WIDTH-1:0] best_score,
  output logic [DATA_WIDTH:0]   margin
);

  argmax_state_t state;
  argmax_state_t state_next;

  logic   done_q;
  logic   trig;
  logic   last;
  idx_t   cnt;
  score_t s;
  score_t best_r;
  score_t second_r;
  idx_t   bidx_r;
  score_t best_n;
  score_t second_n;
  idx_t   bidx_n;

  assign trig    = dnn_done & ~done_q;
  assign last    = (cnt == IDX_WIDTH'(N_CLASSES - 1));
  assign s       = score;
  assign out_idx = cnt;

  top2_update u_top2 (
    .first       (cnt == '0),
    .s           (s),
    .cnt         (cnt),
    .best        (best_r),
    .second      (second_r),
    .bidx        (bidx_r),
    .best_next   (best_n),
    .second_next (second_n),
    .bidx_next   (bidx_n)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a new trigger in HOLD wins over the acknowledge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (trig) state_next = SCAN;
      SCAN: if (last) state_next = HOLD;
      HOLD: begin
        if (trig)            state_next = SCAN;
        else if (result_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Edge detector, scan counter, running top-2 and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q       <= 1'b0;
      cnt          <= '0;
      best_r       <= '0;
      second_r     <= '0;
      bidx_r       <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      done_q       <= dnn_done;
      busy         <= (state_next == SCAN);
      result_valid <= (state_next == HOLD);
      if (state == SCAN) begin
        best_r   <= best_n;
        second_r <= second_n;
        bidx_r   <= bidx_n;
        cnt      <= last ? '0 : cnt + IDX_WIDTH'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  // Result fields capture on the final scan cycle and hold until the next scan completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit      <= '0;
      best_score <= '0;
      margin     <= '0;
    end else if (state == SCAN && last) begin
      digit      <= bidx_n;
      best_score <= best_n;
      margin     <= {best_n[DATA_WIDTH-1], best_n} - {second_n[DATA_WIDTH-1], second_n};
    end
  end

endmodule

// File: tb/tb_argmax_classifier_fix16.sv
// Directed bench for argmax_classifier_fix16 with a 10-entry score array as the inference top.
module tb_argmax_classifier_fix16;

  logic        clk = 1'b0;
  logic        rst;
  logic        dnn_done;
  logic [3:0]  out_idx;
  logic [15:0] score;
  logic        busy;
  logic        result_valid;
  logic        result_ack;
  logic [3:0]  digit;
  logic [15:0] best_score;
  logic [16:0] margin;

  logic [15:0] scores [10];

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign score = (out_idx < 4'd10) ? scores[out_idx] : 16'h0000;

  argmax_classifier_fix16 dut (
    .clk          (clk),
    .rst          (rst),
    .dnn_done     (dnn_done),
    .out_idx      (out_idx),
    .score        (score),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .digit        (digit),
    .best_score   (best_score),
    .margin       (margin)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise dnn_done for one cycle; returns at the first SCAN cycle sample.
  task automatic pulse_done();
    dnn_done = 1'b1;
    step();
    dnn_done = 1'b0;
  endtask

  // Bounded wait for result_valid, counting busy cycles from the current sample.
  task automatic wait_result(output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = 0;
    while (!result_valid && cycles < 30) begin
      if (busy) busy_cnt++;
      step();
      cycles++;
    end
  endtask

  task automatic ack_result();
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    step();
  endtask

  task automatic load_fill(input logic [15:0] v);
    for (int i = 0; i < 10; i++) scores[i] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || out_idx !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy=%b valid=%b out_idx=%0d, required 0/0/0", busy, result_valid, out_idx);
    end
    vectors++;
    if (digit !== 4'd0 || best_score !== 16'h0000 || margin !== 17'h00000) begin
      miscompares++;
      $display("FAIL reset_result: digit=%0d best=%h margin=%h, required 0/0000/00000", digit, best_score, margin);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int cyc, bc;
    load_fill(16'h0000);
    scores[0] = 16'h0100; scores[1] = 16'h0200; scores[2] = 16'h7F00; scores[3] = 16'h0300;
    pulse_done();
    vectors++;
    if (busy !== 1'b1 || out_idx !== 4'd0) begin
      miscompares++;
      $display("FAIL basic_first_scan: busy=%b out_idx=%0d, required 1/0", busy, out_idx);
    end
    step();
    vectors++;
    if (out_idx !== 4'd1) begin
      miscompares++;
      $display("FAIL basic_out_idx: out_idx=%0d, required 1", out_idx);
    end
    wait_result(cyc, bc);
    vectors++;
    if (cyc !== 9 || bc !== 9 || result_valid !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_latency: cycles=%0d busy_cnt=%0d valid=%b busy=%b, required 9/9/1/0", cyc, bc, result_valid, busy);
    end
    vectors++;
    if (digit !== 4'd2 || best_score !== 16'h7F00 || margin !== 17'h07C00 || out_idx !== 4'd0) begin
      miscompares++;
      $display("FAIL basic_result: digit=%0d best=%h margin=%h out_idx=%0d, required 2/7f00/07c00/0", digit, best_score, margin, out_idx);
    end
    ack_result();
  endtask

  task automatic test_tie();
    int cyc, bc;
    load_fill(16'h4000);
    pulse_done();
    wait_result(cyc, bc);
    vectors++;
    if (cyc !== 10 || bc !== 10 || digit !== 4'd0 || best_score !== 16'h4000 || margin !== 17'h00000) begin
      miscompares++;
      $display("FAIL tie: cycles=%0d busy=%0d digit=%0d best=%h margin=%h, required 10/10/0/4000/00000", cyc, bc, digit, best_score, margin);
    end
    ack_result();
  endtask

  task automatic test_negative();
    int cyc, bc;
    scores[0] = 16'hFF9C; scores[1] = 16'hFFCE; scores[2] = 16'hFFE2; scores[3] = 16'hFFEC;
    scores[4] = 16'hFFFE; scores[5] = 16'hFFD8; scores[6] = 16'hFFC4; scores[7] = 16'hFFBA;
    scores[8] = 16'hFFB0; scores[9] = 16'hFFFF;
    pulse_done();
    wait_result(cyc, bc);
    vectors++;
    if (result_valid !== 1'b1 || digit !== 4'd9 || best_score !== 16'hFFFF || margin !== 17'h00001) begin
      miscompares++;
      $display("FAIL negative: valid=%b digit=%0d best=%h margin=%h, required 1/9/ffff/00001", result_valid, digit, best_score, margin);
    end
    ack_result();
  endtask

  task automatic test_extremes();
    int cyc, bc;
    load_fill(16'h8000);
    scores[5] = 16'h7FFF;
    pulse_done();
    wait_result(cyc, bc);
    vectors++;
    if (digit !== 4'd5 || best_score !== 16'h7FFF || margin !== 17'h0FFFF) begin
      miscompares++;
      $display("FAIL extremes_max: digit=%0d best=%h margin=%h, required 5/7fff/0ffff", digit, best_score, margin);
    end
    ack_result();
    load_fill(16'h8000);
    pulse_done();
    wait_result(cyc, bc);
    vectors++;
    if (digit !== 4'd0 || best_score !== 16'h8000 || margin !== 17'h00000) begin
      miscompares++;
      $display("FAIL extremes_allmin: digit=%0d best=%h margin=%h, required 0/8000/00000", digit, best_score, margin);
    end
    ack_result();
  endtask

  task automatic test_level_hold();
    int bc;
    bc = 0;
    load_fill(16'h0010);
    scores[3] = 16'h0050;
    dnn_done = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (busy) bc++;
    end
    dnn_done = 1'b0;
    vectors++;
    if (bc !== 10 || result_valid !== 1'b1 || digit !== 4'd3 || margin !== 17'h00040) begin
      miscompares++;
      $display("FAIL level_hold: busy_cnt=%0d valid=%b digit=%0d margin=%h, required 10/1/3/00040", bc, result_valid, digit, margin);
    end
    step();
  endtask

  task automatic test_ack_retrigger();
    int cyc, bc;
    load_fill(16'h0001);
    scores[8] = 16'h0201;
    vectors++;
    if (result_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL retrig_precond: valid=%b, required 1", result_valid);
    end
    dnn_done   = 1'b1;
    result_ack = 1'b1;
    step();
    dnn_done   = 1'b0;
    result_ack = 1'b0;
    vectors++;
    if (result_valid !== 1'b0 || busy !== 1'b1 || digit !== 4'd3) begin
      miscompares++;
      $display("FAIL retrig_start: valid=%b busy=%b digit=%0d, required 0/1/3", result_valid, busy, digit);
    end
    wait_result(cyc, bc);
    vectors++;
    if (cyc !== 10 || digit !== 4'd8 || best_score !== 16'h0201 || margin !== 17'h00200) begin
      miscompares++;
      $display("FAIL retrig_result: cycles=%0d digit=%0d best=%h margin=%h, required 10/8/0201/00200", cyc, digit, best_score, margin);
    end
    ack_result();
  endtask

  task automatic test_reset_midscan();
    int cyc, bc;
    load_fill(16'h0002);
    scores[6] = 16'h0102;
    pulse_done();
    for (int i = 0; i < 5; i++) step();
    vectors++;
    if (out_idx !== 4'd5 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_pre: out_idx=%0d busy=%b, required 5/1", out_idx, busy);
    end
    rst = 1'b1;
    step();
    vectors++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || out_idx !== 4'd0 || digit !== 4'd0 ||
        best_score !== 16'h0000 || margin !== 17'h00000) begin
      miscompares++;
      $display("FAIL midreset_outputs: busy=%b valid=%b out_idx=%0d digit=%0d best=%h margin=%h, required all zero",
               busy, result_valid, out_idx, digit, best_score, margin);
    end
    rst = 1'b0;
    bc = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (busy || result_valid) bc++;
    end
    vectors++;
    if (bc !== 0) begin
      miscompares++;
      $display("FAIL midreset_idle: active_cycles=%0d, required 0", bc);
    end
    scores[7] = 16'h0300;
    pulse_done();
    wait_result(cyc, bc);
    vectors++;
    if (cyc !== 10 || digit !== 4'd7 || best_score !== 16'h0300 || margin !== 17'h001FE) begin
      miscompares++;
      $display("FAIL midreset_rescan: cycles=%0d digit=%0d best=%h margin=%h, required 10/7/0300/001fe", cyc, digit, best_score, margin);
    end
    ack_result();
  endtask

  task automatic test_midscan_trigger();
    int bc;
    load_fill(16'hFF00);
    scores[1] = 16'h0010;
    scores[4] = 16'h0008;
    pulse_done();
    bc = 0;
    for (int i = 0; i < 15; i++) begin
      if (busy) bc++;
      dnn_done = (i == 3);
      step();
    end
    dnn_done = 1'b0;
    vectors++;
    if (bc !== 10 || result_valid !== 1'b1 || digit !== 4'd1 || margin !== 17'h00008) begin
      miscompares++;
      $display("FAIL midscan_trig: busy_cnt=%0d valid=%b digit=%0d margin=%h, required 10/1/1/00008", bc, result_valid, digit, margin);
    end
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    vectors++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || digit !== 4'd1 || best_score !== 16'h0010) begin
      miscompares++;
      $display("FAIL ack_hold: valid=%b busy=%b digit=%0d best=%h, required 0/0/1/0010", result_valid, busy, digit, best_score);
    end
  endtask

  initial begin
    rst        = 1'b1;
    dnn_done   = 1'b0;
    result_ack = 1'b0;
    load_fill(16'h0000);
    test_reset();
    test_basic();
    test_tie();
    test_negative();
    test_extremes();
    test_level_hold();
    test_ack_retrigger();
    test_reset_midscan();
    test_midscan_trigger();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
